bn_stat_ctrl: RTL and testbench
===============================

BN_STAT_CTRL -- requirements
Module: bn_stat_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 16, sample/statistic width.
- MINI_BATCH, 64, samples per channel.
- ADDR_WIDTH, $clog2(MINI_BATCH), sample-counter width.
- CH_WIDTH, 8, channel-count width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- start_i, in, 1, begin a run (sampled only in IDLE).
- num_ch_i, in, CH_WIDTH, channels in the run (sampled with start_i).
- busy_o, out, 1, high in every state except IDLE.
- done_o, out, 1, one-cycle pulse when the run ends.
- in_valid_i, in, 1, sample valid.
- in_data_i, in, DATA_WIDTH signed, sample.
- in_ready_o, out, 1, sample accepted when in_valid_i && in_ready_o.
- cal_valid_o, out, 1, drives the stats unit's valid_in.
- cal_max_o / cal_min_o / cal_sum_o, out, DATA_WIDTH signed each, to the stats unit's max_in / min_in / sum_in.
- cal_valid_i, in, 1, from the stats unit's valid_out.
- cal_avg_i / cal_std_i, in, DATA_WIDTH signed each, from the stats unit's avg_out / stan_dev_out.
- out_valid_o, out, 1, result valid.
- out_ready_i, in, 1, result consumed when out_valid_o && out_ready_i.
- out_avg_o / out_std_o, out, DATA_WIDTH signed each, held result.
- out_ch_o, out, CH_WIDTH, channel index of the held result.

Function
REQ-003 The FSM SHALL have states IDLE, ACC, CAL, OUT, one transition evaluation per clk edge.
REQ-004 In IDLE with start_i=1:
- num_ch_i is latched and the channel index cleared to 0.
- If num_ch_i=0: done_o pulses on the next cycle and the FSM stays IDLE.
- Otherwise the FSM enters ACC.
REQ-005 start_i SHALL be ignored outside IDLE.
REQ-006 in_ready_o SHALL equal 1 only in ACC; no sample is accepted in any other state.
REQ-007 The first accepted sample of a channel SHALL load max=min=sum=in_data_i. Each later accepted sample SHALL update:
- max = signed max(max, x).
- min = signed min(min, x).
- sum = sum + x, modulo 2^DATA_WIDTH, wrap-around with no saturation.
REQ-008 The sample counter SHALL increment per accepted sample. On the MINI_BATCH-th accepted sample the counter wraps to 0 and the FSM enters CAL the next cycle. Cycles with in_valid_i=0 SHALL NOT advance the counter.
REQ-009 cal_max_o, cal_min_o and cal_sum_o SHALL be driven from the accumulator registers at all times. cal_valid_o SHALL be 1 only in CAL.
REQ-010 In CAL with cal_valid_i=1:
- cal_avg_i and cal_std_i are registered into out_avg_o and out_std_o.
- out_ch_o is set to the channel index.
- The FSM enters OUT.
If cal_valid_i=0, the FSM SHALL remain in CAL.
REQ-011 out_valid_o SHALL be 1 only in OUT. out_avg_o, out_std_o and out_ch_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-012 On the OUT handshake:
- If channel index+1 < the latched count: the index increments and the FSM enters ACC.
- Otherwise: done_o pulses for one cycle and the FSM enters IDLE.
REQ-013 Minimum latency SHALL be one cycle from the last accepted sample to CAL, and one cycle from CAL to out_valid_o=1, giving 2 cycles from the last sample to a valid result.
REQ-014 busy_o SHALL be 0 in IDLE. It SHALL also be 0 during the done_o pulse cycle.

Reset
REQ-015 rst=1 at any clk edge, including mid-channel or while OUT is stalled, SHALL:
- Force IDLE.
- Clear the counter, channel index, latched count and accumulators.
- Drive all outputs to 0: busy_o, done_o, in_ready_o, cal_valid_o, cal_* data, out_valid_o, out_* data.
REQ-016 Samples presented during reset, or in the cycle reset is released, SHALL NOT be accepted.

Verification (MINI_BATCH=4, ADDR_WIDTH=2, stats unit instantiated behind the cal_* ports)
REQ-017 start_i with num_ch_i=1, samples 1,2,3,6 -> cal_max_o=6, cal_min_o=1, cal_sum_o=12; result out_avg_o=3, out_std_o=20, out_ch_o=0; done_o pulses once.
REQ-018 num_ch_i=2, channel 0 samples -2,-2,-2,-2 and channel 1 samples 5,-3,0,2 -> results (avg -2, std 0, ch 0) then (avg 1, std 32, ch 1); done_o after the second handshake only.
REQ-019 in_valid_i toggled every other cycle during ACC -> counter advances only on accepted samples; results match REQ-017.
REQ-020 out_ready_i held 0 for 10 cycles in OUT -> out_valid_o and data stable; in_ready_o=0 throughout; no sample lost after release.
REQ-021 rst asserted after 2 of 4 samples, then a new start_i -> the fresh run ignores the partial data; all outputs 0 during reset.
REQ-022 start_i with num_ch_i=0 -> done_o pulses on the next cycle, busy_o stays 0, no cal_valid_o.

Source files
------------

// File: rtl/bn_stat_ctrl.sv
// Batch-norm statistics controller: accumulates max/min/sum over MINI_BATCH samples per
// channel, hands them to an external stats unit and holds each channel's avg/std result.
module bn_stat_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MINI_BATCH = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(MINI_BATCH),
  parameter int unsigned CH_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [CH_WIDTH-1:0]          num_ch_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic                         in_valid_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  output logic                         in_ready_o,
  output logic                         cal_valid_o,
  output logic signed [DATA_WIDTH-1:0] cal_max_o,
  output logic signed [DATA_WIDTH-1:0] cal_min_o,
  output logic signed [DATA_WIDTH-1:0] cal_sum_o,
  input  logic                         cal_valid_i,
  input  logic signed [DATA_WIDTH-1:0] cal_avg_i,
  input  logic signed [DATA_WIDTH-1:0] cal_std_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [DATA_WIDTH-1:0] out_avg_o,
  output logic signed [DATA_WIDTH-1:0] out_std_o,
  output logic [CH_WIDTH-1:0]          out_ch_o
);

  typedef enum logic [1:0] {StIdle, StAcc, StCal, StOut} state_e;

  localparam logic [ADDR_WIDTH-1:0] CntLast = ADDR_WIDTH'(MINI_BATCH - 1);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
  logic [CH_WIDTH-1:0]            ch_q, ch_d;
  logic [CH_WIDTH-1:0]            num_q, num_d;
  logic signed [DATA_WIDTH-1:0]   max_q, max_d, min_q, min_d, sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0]   avg_q, avg_d, std_q, std_d;
  logic [CH_WIDTH-1:0]            och_q, och_d;
  logic                           done_q, done_d;
  logic [CH_WIDTH:0]              ch_inc;

  assign ch_inc = {1'b0, ch_q} + (CH_WIDTH + 1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    num_d   = num_q;
    max_d   = max_q;
    min_d   = min_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    std_d   = std_q;
    och_d   = och_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d = num_ch_i;
          ch_d  = '0;
          if (num_ch_i == '0) done_d = 1'b1;
          else                state_d = StAcc;
        end
      end
      StAcc: begin
        if (in_valid_i) begin
          // Counter at zero marks the first sample of a channel: seed all three stats.
          if (cnt_q == '0) begin
            max_d = in_data_i;
            min_d = in_data_i;
            sum_d = in_data_i;
          end else begin
            max_d = (in_data_i > max_q) ? in_data_i : max_q;
            min_d = (in_data_i < min_q) ? in_data_i : min_q;
            sum_d = sum_q + in_data_i;
          end
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StCal;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      StCal: begin
        if (cal_valid_i) begin
          avg_d   = cal_avg_i;
          std_d   = cal_std_i;
          och_d   = ch_q;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          if (ch_inc < {1'b0, num_q}) begin
            ch_d    = ch_inc[CH_WIDTH-1:0];
            state_d = StAcc;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      num_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      std_q   <= '0;
      och_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      num_q   <= num_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      std_q   <= std_d;
      och_q   <= och_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign in_ready_o  = (state_q == StAcc);
  assign cal_valid_o = (state_q == StCal);
  assign cal_max_o   = max_q;
  assign cal_min_o   = min_q;
  assign cal_sum_o   = sum_q;
  assign out_valid_o = (state_q == StOut);
  assign out_avg_o   = avg_q;
  assign out_std_o   = std_q;
  assign out_ch_o    = och_q;

endmodule

// File: tb/tb_bn_stat_ctrl.sv
// Directed bench for bn_stat_ctrl with MINI_BATCH=4 and a combinational stats-unit model
// (avg = sum/4, std = (max-min)*4) behind the cal_* ports.
module tb_bn_stat_ctrl;

  localparam int DW = 16;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i;
  logic [CW-1:0]        num_ch_i;
  logic                 busy_o, done_o;
  logic                 in_valid_i;
  logic signed [DW-1:0] in_data_i;
  logic                 in_ready_o;
  logic                 cal_valid_o;
  logic signed [DW-1:0] cal_max_o, cal_min_o, cal_sum_o;
  logic                 cal_valid_i;
  logic signed [DW-1:0] cal_avg_i, cal_std_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic signed [DW-1:0] out_avg_o, out_std_o;
  logic [CW-1:0]        out_ch_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cal_valid_i = cal_valid_o;
  assign cal_avg_i   = cal_sum_o >>> 2;
  assign cal_std_i   = (cal_max_o - cal_min_o) <<< 2;

  bn_stat_ctrl #(
    .DATA_WIDTH (DW),
    .MINI_BATCH (4),
    .ADDR_WIDTH (2),
    .CH_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .num_ch_i    (num_ch_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .cal_valid_o (cal_valid_o),
    .cal_max_o   (cal_max_o),
    .cal_min_o   (cal_min_o),
    .cal_sum_o   (cal_sum_o),
    .cal_valid_i (cal_valid_i),
    .cal_avg_i   (cal_avg_i),
    .cal_std_i   (cal_std_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_avg_o   (out_avg_o),
    .out_std_o   (out_std_o),
    .out_ch_o    (out_ch_o)
  );

  typedef struct {
    logic signed [DW-1:0] s [4];
    logic signed [DW-1:0] emax, emin, esum, eavg, estd;
    logic                 gap;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic signed [DW-1:0] a, b, c, d,
                              input logic signed [DW-1:0] mx, mn, sm, av, sd,
                              input logic g);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.emax = mx; v.emin = mn; v.esum = sm; v.eavg = av; v.estd = sd; v.gap = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {20'd0, busy_o, done_o, in_ready_o, cal_valid_o, out_valid_o}, 32'd0);
    chk({name, "_cal"}, {cal_max_o | cal_min_o | cal_sum_o}, 32'd0);
    chk({name, "_out"}, {out_avg_o | out_std_o, 8'd0 | out_ch_o}, 32'd0);
  endtask

  // Feeds one channel from ACC through its OUT handshake.
  task automatic run_chan(input vec_t v, input logic [CW-1:0] ch, input logic last);
    for (int i = 0; i < 4; i++) begin
      if (v.gap) begin
        in_valid_i = 1'b0;
        in_data_i  = 16'sd99;
        tick();
        chk("gap_ready", {31'd0, in_ready_o}, 32'd1);
      end
      in_valid_i = 1'b1;
      in_data_i  = v.s[i];
      tick();
    end
    in_valid_i = 1'b0;
    chk("cal_valid", {31'd0, cal_valid_o}, 32'd1);
    chk("cal_ready0", {31'd0, in_ready_o}, 32'd0);
    chk("cal_max", cal_max_o, v.emax);
    chk("cal_min", cal_min_o, v.emin);
    chk("cal_sum", cal_sum_o, v.esum);
    tick();
    chk("out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("out_avg", out_avg_o, v.eavg);
    chk("out_std", out_std_o, v.estd);
    chk("out_ch", {24'd0, out_ch_o}, {24'd0, ch});
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("hs_done", {31'd0, done_o}, {31'd0, last});
    chk("hs_busy", {31'd0, busy_o}, {31'd0, ~last});
    chk("hs_ready", {31'd0, in_ready_o}, {31'd0, ~last});
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start_i  = 1'b1;
    num_ch_i = n;
    tick();
    start_i  = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic signed [DW-1:0] hold_avg, hold_std;

    vecs[0] = mk(16'sd1, 16'sd2, 16'sd3, 16'sd6, 16'sd6, 16'sd1, 16'sd12, 16'sd3, 16'sd20, 1'b0);
    vecs[1] = mk(-16'sd2, -16'sd2, -16'sd2, -16'sd2, -16'sd2, -16'sd2, -16'sd8, -16'sd2,
                 16'sd0, 1'b0);
    vecs[2] = mk(16'sd5, -16'sd3, 16'sd0, 16'sd2, 16'sd5, -16'sd3, 16'sd4, 16'sd1, 16'sd32, 1'b0);
    // Sum wraps to -32768; (32767-0)*4 wraps to -4.
    vecs[3] = mk(16'sd32767, 16'sd1, 16'sd0, 16'sd0, 16'sd32767, 16'sd0, -16'sd32768,
                 -16'sd8192, -16'sd4, 1'b0);
    vecs[4] = mk(16'sd1, 16'sd2, 16'sd3, 16'sd6, 16'sd6, 16'sd1, 16'sd12, 16'sd3, 16'sd20, 1'b1);

    rst = 1'b1; start_i = 1'b0; num_ch_i = '0; in_valid_i = 1'b1; in_data_i = 16'sd55;
    out_ready_i = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    in_valid_i = 1'b0;
    chk("release_ready", {31'd0, in_ready_o}, 32'd0);
    chk("release_sum", cal_sum_o, 32'd0);

    for (int k = 0; k < 5; k++) begin
      do_start(8'd1);
      chk("start_busy", {31'd0, busy_o}, 32'd1);
      run_chan(vecs[k], 8'd0, 1'b1);
      tick();
      chk("done_pulse", {31'd0, done_o}, 32'd0);
    end

    // Two channels; channel 0 result stalled 10 cycles with samples and a stray start offered.
    do_start(8'd2);
    v = vecs[1];
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = v.s[i];
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    chk("st_valid", {31'd0, out_valid_o}, 32'd1);
    hold_avg = out_avg_o;
    hold_std = out_std_o;
    chk("st_avg0", out_avg_o, -16'sd2);
    in_valid_i = 1'b1;
    in_data_i  = 16'sd100;
    start_i    = 1'b1;
    num_ch_i   = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
      chk("stall_ready", {31'd0, in_ready_o}, 32'd0);
      chk("stall_data", {out_avg_o, out_std_o}, {hold_avg, hold_std});
      chk("stall_done", {31'd0, done_o}, 32'd0);
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    chk("stall_sum", cal_sum_o, -16'sd8);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("ch0_done", {31'd0, done_o}, 32'd0);
    chk("ch0_ready", {31'd0, in_ready_o}, 32'd1);
    run_chan(vecs[2], 8'd1, 1'b1);
    tick();

    // Reset part-way through a channel, then a clean run.
    do_start(8'd1);
    in_valid_i = 1'b1;
    in_data_i  = 16'sd7;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    tick();
    in_valid_i = 1'b0;
    chk("mid_rel_sum", cal_sum_o, 32'd0);
    do_start(8'd1);
    run_chan(vecs[0], 8'd0, 1'b1);
    tick();

    // Reset while OUT is stalled.
    do_start(8'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = vecs[2].s[i];
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("out_rst");
    rst = 1'b0;
    tick();

    // Zero-channel run.
    do_start(8'd0);
    chk("zero_done", {31'd0, done_o}, 32'd1);
    chk("zero_busy", {31'd0, busy_o}, 32'd0);
    chk("zero_cal", {31'd0, cal_valid_o}, 32'd0);
    tick();
    chk("zero_done_end", {31'd0, done_o}, 32'd0);
    chk("zero_busy_end", {31'd0, busy_o | cal_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
